// File: rtl/rominit_router.sv
// Download router: decodes the ioctl byte stream into NREG ROM/RAM init regions.
// A first-word-fall-through FIFO decouples the host from target backpressure.
module rominit_router #(
  parameter int unsigned          NREG  = 2,
  parameter int unsigned          AW    = 25,
  parameter int unsigned          RAW   = 12,
  parameter int unsigned          DEPTH = 4,
  parameter logic [NREG*AW-1:0]   BASE  = {25'h1000, 25'h0000},
  parameter logic [NREG*AW-1:0]   SIZE  = {25'h0400, 25'h1000},
  parameter logic [NREG*8-1:0]    INDEX = {8'h00, 8'h00}
) (
  input  logic            CLK,
  input  logic            RESB,
  input  logic            IOCTL_DOWNLOAD,
  input  logic [7:0]      IOCTL_INDEX,
  input  logic            IOCTL_WR,
  input  logic [AW-1:0]   IOCTL_ADDR,
  input  logic [7:0]      IOCTL_DOUT,
  output logic            IOCTL_WAIT,
  output logic [NREG-1:0] ROMINIT_SEL,
  output logic [RAW-1:0]  ROMINIT_ADDR,
  output logic [7:0]      ROMINIT_DATA,
  output logic            ROMINIT_VALID,
  input  logic            ROMINIT_READY,
  output logic [NREG-1:0] LOADED,
  output logic            MISS,
  output logic            OVERFLOW,
  output logic            DONE
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [PW:0] CntMax  = (PW+1)'(DEPTH);
  localparam logic [PW:0] CntHigh = (PW+1)'(DEPTH - 1);
  localparam logic [PW:0] CntOne  = (PW+1)'(1);
  localparam logic [PW-1:0] PtrOne = PW'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic            dl_q, armed_q, pend_q, pend_d;
  logic [NREG-1:0] loaded_q, loaded_d;
  logic            miss_q, miss_d, ovf_q, ovf_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;

  logic [NREG-1:0] mem_sel  [DEPTH];
  logic [RAW-1:0]  mem_addr [DEPTH];
  logic [7:0]      mem_data [DEPTH];

  logic            hit;
  logic [NREG-1:0] hit_sel;
  logic [RAW-1:0]  hit_addr;
  logic [AW:0]     addr_ext, lo_ext, hi_ext;

  // Walk regions high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_addr = '0;
    addr_ext = {1'b0, IOCTL_ADDR};
    lo_ext   = '0;
    hi_ext   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      lo_ext = {1'b0, BASE[i*AW +: AW]};
      hi_ext = lo_ext + {1'b0, SIZE[i*AW +: AW]};
      if (IOCTL_INDEX == INDEX[i*8 +: 8] && addr_ext >= lo_ext && addr_ext < hi_ext) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_addr   = RAW'(IOCTL_ADDR - BASE[i*AW +: AW]);
      end
    end
  end

  logic dl_rise, dl_fall, empty, full, in_load, strobe, push, pop, start;

  // armed_q blocks a level-high download after reset from looking like a fresh start.
  assign dl_rise = IOCTL_DOWNLOAD & ~dl_q & armed_q;
  assign dl_fall = ~IOCTL_DOWNLOAD & dl_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntMax);
  assign in_load = (state_q == StLoad);
  assign strobe  = in_load & IOCTL_WR;
  assign push    = strobe & hit & ~full;
  assign pop     = ~empty & ROMINIT_READY;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntOne;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dl_rise) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
      StLoad: begin
        if (dl_fall) state_d = StDrain;
      end
      StDrain: begin
        if (dl_rise) pend_d = 1'b1;
        if (cnt_d == '0) state_d = StDone;
      end
      StDone: begin
        pend_d = 1'b0;
        if (pend_q || dl_rise) begin
          state_d = StLoad;
          start   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    loaded_d = loaded_q;
    miss_d   = miss_q;
    ovf_d    = ovf_q;
    if (start) begin
      loaded_d = '0;
      miss_d   = 1'b0;
      ovf_d    = 1'b0;
    end
    if (pop) loaded_d = loaded_d | ROMINIT_SEL;
    if (strobe && !hit) miss_d = 1'b1;
    if (strobe && hit && full) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q  <= StIdle;
      dl_q     <= 1'b0;
      armed_q  <= 1'b0;
      pend_q   <= 1'b0;
      loaded_q <= '0;
      miss_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      dl_q     <= IOCTL_DOWNLOAD;
      armed_q  <= armed_q | ~IOCTL_DOWNLOAD;
      pend_q   <= pend_d;
      loaded_q <= loaded_d;
      miss_q   <= miss_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_sel[wptr_q]  <= hit_sel;
      mem_addr[wptr_q] <= hit_addr;
      mem_data[wptr_q] <= IOCTL_DOUT;
    end
  end

  assign ROMINIT_VALID = ~empty;
  assign ROMINIT_SEL   = empty ? '0 : mem_sel[rptr_q];
  assign ROMINIT_ADDR  = empty ? '0 : mem_addr[rptr_q];
  assign ROMINIT_DATA  = empty ? '0 : mem_data[rptr_q];
  // One slot of headroom remains when WAIT rises, for a strobe already in flight.
  assign IOCTL_WAIT    = (cnt_q >= CntHigh) || (state_q == StDrain) || (state_q == StDone);
  assign LOADED        = loaded_q;
  assign MISS          = miss_q;
  assign OVERFLOW      = ovf_q;
  assign DONE          = (state_q == StDone);

endmodule
